// File: rtl/eforth1_pkg.sv
// Shared eForth1 definitions: memory geometry, cell byte order and the
// state encoding of the 16-bit-over-8-bit memory bridge.
package eforth1_pkg;

  localparam int ASZ        = 17;
  localparam int DSZ        = 16;
  localparam int BIG_ENDIAN = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_W1,
    ST_R0,
    ST_R1,
    ST_RL,
    ST_DONE
  } mb16_st_e;

  // Byte that goes to the cell's base address.
  function automatic logic [7:0] first_byte(input logic [DSZ-1:0] v, input logic wide);
    if (!wide) return v[7:0];
    return (BIG_ENDIAN != 0) ? v[15:8] : v[7:0];
  endfunction

  // Byte that goes to base address + 1 of a cell.
  function automatic logic [7:0] second_byte(input logic [DSZ-1:0] v);
    return (BIG_ENDIAN != 0) ? v[7:0] : v[15:8];
  endfunction

  function automatic logic [DSZ-1:0] join_cell(input logic [7:0] at_a, input logic [7:0] at_a1);
    return (BIG_ENDIAN != 0) ? {at_a, at_a1} : {at_a1, at_a};
  endfunction

endpackage

// File: rtl/mb16_bridge.sv
// Cell/byte request bridge onto a single-port byte memory with a registered
// read port. One FSM sequences one or two byte accesses per request.
module mb16_bridge
  import eforth1_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic           we,
  input  logic           wide,
  input  logic [ASZ-1:0] ai,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] vo,
  output logic           ack,
  output logic           busy,
  output logic [ASZ-1:0] m_ai,
  output logic [7:0]     m_vi,
  output logic           m_we,
  input  logic [7:0]     m_vo
);

  // Handshake: req/we/wide/ai/vi are sampled only in IDLE; ack pulses for one
  // cycle per accepted request; a req seen while not IDLE is dropped.

  mb16_st_e       state;
  logic           wide_r;
  logic [DSZ-1:0] vi_r;
  logic [ASZ-1:0] a_r;
  logic [7:0]     hi_r;

  // Memory-side outputs are loaded on entry to a state, so the address is on
  // the bus during that state and its read byte arrives during the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      wide_r <= 1'b0;
      vi_r   <= '0;
      a_r    <= '0;
      hi_r   <= '0;
      vo     <= '0;
      ack    <= 1'b0;
      busy   <= 1'b0;
      m_ai   <= '0;
      m_vi   <= '0;
      m_we   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= 1'b0;
          if (req) begin
            wide_r <= wide;
            vi_r   <= vi;
            a_r    <= ai;
            busy   <= 1'b1;
            m_ai   <= ai;
            if (we) begin
              m_we  <= 1'b1;
              m_vi  <= first_byte(vi, wide);
              state <= ST_W0;
            end else begin
              m_we  <= 1'b0;
              state <= ST_R0;
            end
          end
        end
        ST_W0: begin
          if (wide_r) begin
            m_ai  <= a_r + 1'b1;
            m_vi  <= second_byte(vi_r);
            state <= ST_W1;
          end else begin
            m_we  <= 1'b0;
            ack   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_W1: begin
          m_we  <= 1'b0;
          ack   <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end
        ST_R0: begin
          if (wide_r) begin
            m_ai  <= a_r + 1'b1;
            state <= ST_R1;
          end else begin
            state <= ST_RL;
          end
        end
        ST_R1: begin
          hi_r  <= m_vo;
          state <= ST_RL;
        end
        ST_RL: begin
          vo    <= wide_r ? join_cell(hi_r, m_vo) : {8'h00, m_vo};
          ack   <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end
        ST_DONE: begin
          ack   <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb16_bridge.sv
// Self-checking bench for mb16_bridge: byte memory with a registered read
// port, a transaction-level model of the bridge, and a per-cycle compare.
module tb_mb16_bridge;

  localparam int MEMSZ = 131072;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, wide;
  logic [16:0] ai;
  logic [15:0] vi;
  logic [15:0] vo;
  logic        ack, busy;
  logic [16:0] m_ai;
  logic [7:0]  m_vi;
  logic        m_we;
  logic [7:0]  m_vo;

  mb16_bridge dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .wide(wide), .ai(ai), .vi(vi),
    .vo(vo), .ack(ack), .busy(busy), .m_ai(m_ai), .m_vi(m_vi), .m_we(m_we),
    .m_vo(m_vo)
  );

  always #5 clk = ~clk;

  // Byte memory: write on the edge, read data registered one cycle later.
  logic [7:0] mem     [0:MEMSZ-1];
  logic [7:0] ref_mem [0:MEMSZ-1];
  always @(posedge clk) begin
    if (m_we) mem[m_ai] <= m_vi;
    m_vo <= mem[m_ai];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Latency L (edges from acceptance to the edge that first sees ack):
  // byte write 2, word write 3, byte read 3, word read 4. The bridge is
  // free again L+1 edges after acceptance.
  typedef struct {
    int          e;
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wq[$];

  int          cyc = 0;
  int          acc = 0;
  int          lat = 0;
  int          free_edge = 0;
  int          acc_cnt = 0;
  bit          act = 1'b0;
  logic        op_we, op_wide;
  logic [15:0] pend_vo;
  logic [15:0] exp_vo = '0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      while (wq.size() > 0 && wq[0].e == cyc) begin
        ref_mem[wq[0].a] = wq[0].d;
        void'(wq.pop_front());
      end
      if (act && cyc >= acc + lat) act = 1'b0;
      if (rst) begin
        wq.delete();
        act = 1'b0;
        free_edge = cyc + 1;
        exp_vo = '0;
      end else if (req && cyc >= free_edge) begin
        acc = cyc;
        op_we = we;
        op_wide = wide;
        lat = we ? (wide ? 3 : 2) : (wide ? 4 : 3);
        free_edge = cyc + lat + 1;
        act = 1'b1;
        acc_cnt++;
        if (we) begin
          wq.push_back('{cyc + 1, ai, wide ? vi[15:8] : vi[7:0]});
          if (wide) wq.push_back('{cyc + 2, ai + 17'd1, vi[7:0]});
        end else begin
          pend_vo = wide ? {ref_mem[ai], ref_mem[ai + 17'd1]} : {8'h00, ref_mem[ai]};
        end
      end
      if (act && !op_we && cyc == acc + lat - 1) exp_vo = pend_vo;
    end
  end

  // ---------------- per-cycle compare ----------------
  int ack_cnt = 0;
  int last_ack_cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        logic e_ack, e_busy, e_we;
        e_ack  = act && (cyc == acc + lat - 1);
        e_busy = act && (cyc <= acc + lat - 2);
        e_we   = act && op_we && (cyc <= acc + (op_wide ? 1 : 0));
        chk("ack", {31'd0, ack}, {31'd0, e_ack});
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("m_we", {31'd0, m_we}, {31'd0, e_we});
        chk("vo", {16'd0, vo}, {16'd0, exp_vo});
        if (ack) begin
          ack_cnt++;
          last_ack_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after the accepting edge with req still asserted.
  task automatic do_op(input logic w, input logic wd, input logic [16:0] a, input logic [15:0] v);
    int n0;
    bit got;
    @(negedge clk);
    req = 1'b1; we = w; wide = wd; ai = a; vi = v;
    n0 = acc_cnt;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != n0) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drop_req();
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (!act && cyc + 1 >= free_edge) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input logic w, input logic wd, input logic [16:0] a, input logic [15:0] v);
    do_op(w, wd, a, v);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_ack, n_acc, bad;
    for (int i = 0; i < MEMSZ; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst = 1'b1; req = 1'b0; we = 1'b0; wide = 1'b0; ai = '0; vi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ai", {15'd0, m_ai}, 32'd0);
    chk("rst_m_vi", {24'd0, m_vi}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_vo", {16'd0, vo}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // word write then read, big-endian bytes
    single(1'b1, 1'b1, 17'h00100, 16'hA55A);
    chk("ww_hi", {24'd0, mem[17'h00100]}, 32'h000000A5);
    chk("ww_lo", {24'd0, mem[17'h00101]}, 32'h0000005A);
    do_op(1'b0, 1'b1, 17'h00100, 16'h0000);
    n_acc = acc;
    wait_idle();
    chk("wr_vo", {16'd0, vo}, 32'h0000A55A);
    chk("wr_latency", last_ack_cyc + 1 - n_acc, 32'd4);

    // byte write/read
    single(1'b1, 1'b0, 17'h00201, 16'hFF3C);
    do_op(1'b0, 1'b0, 17'h00201, 16'h0000);
    n_acc = acc;
    wait_idle();
    chk("br_vo", {16'd0, vo}, 32'h0000003C);
    chk("br_latency", last_ack_cyc + 1 - n_acc, 32'd3);
    chk("b_neighbour", {24'd0, mem[17'h00200]}, 32'd0);

    // address wrap
    single(1'b1, 1'b1, 17'h1FFFF, 16'h1234);
    chk("wrap_hi", {24'd0, mem[17'h1FFFF]}, 32'h00000012);
    chk("wrap_lo", {24'd0, mem[17'h00000]}, 32'h00000034);
    single(1'b0, 1'b1, 17'h1FFFF, 16'h0000);
    chk("wrap_vo", {16'd0, vo}, 32'h00001234);

    // req during a busy word read is dropped
    n_ack = ack_cnt;
    do_op(1'b0, 1'b1, 17'h00100, 16'h0000);
    @(negedge clk);
    we = 1'b1; ai = 17'h00300; vi = 16'hFFFF;
    repeat (3) @(negedge clk);
    req = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("busy_one_ack", ack_cnt - n_ack, 32'd1);
    chk("busy_no_write", {24'd0, mem[17'h00300]}, 32'd0);

    // reset during W0 of a word write
    n_ack = ack_cnt;
    do_op(1'b1, 1'b1, 17'h00400, 16'hBEEF);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", {31'd0, m_we}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_ack", ack_cnt - n_ack, 32'd0);
    chk("rst_mid_401", {24'd0, mem[17'h00401]}, 32'd0);
    single(1'b1, 1'b1, 17'h00410, 16'h7777);
    single(1'b0, 1'b1, 17'h00410, 16'h0000);
    chk("after_rst_vo", {16'd0, vo}, 32'h00007777);

    // randomized back-to-back traffic over a small address pool
    for (int n = 0; n < 250; n++) begin
      logic [16:0] a;
      a = ($urandom_range(0, 1) == 1) ? 17'h1FFF8 + 17'($urandom_range(0, 7))
                                      : 17'h08000 + 17'($urandom_range(0, 15));
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        drop_req();
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);

    bad = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image_mismatches", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
